// File: rtl/packet_reader_pkg.sv
// ----------------------------------------------------------------------------
// packet_reader_pkg
// Shared definitions for the packet buffer reader and writer: default sizing
// of the packet RAM and the length FIFO, the inter-packet gap, and the
// reader FSM state encoding.
// No ports (package only).
// ----------------------------------------------------------------------------
package packet_reader_pkg;

   // Default byte width of the packet RAM and the transmit interface
   localparam int PKT_DATA_WIDTH        = 8;

   // Smallest and largest frame the buffer is sized for
   localparam int PKT_MIN_PACKET_LENGHT = 64;
   localparam int PKT_MAX_PACKET_LENGHT = 1536;

   // The RAM holds two maximum-size frames so writer and reader can overlap
   localparam int PKT_DEPTH_RAM         = 2 * PKT_MAX_PACKET_LENGHT;

   // Minimum number of idle transmit cycles between two frames
   localparam int PKT_IFG               = 12;

   // Reader FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } pkt_rd_state_e;

endpackage : packet_reader_pkg

// File: rtl/packet_reader_rd_ptr.sv
// ----------------------------------------------------------------------------
// packet_rd_ptr
// Wrapping read pointer into the packet RAM plus the "free" pointer that
// tells the writer how far RAM has been released.
//
// Ports
//   iclk        clock
//   i_rst       synchronous active-high reset, clears both pointers
//   i_inc       advance the read pointer by one address
//   i_skip      advance the read pointer by i_skip_len (discarded frame)
//   i_skip_len  number of addresses to skip
//   i_rel       copy the updated read pointer into the free pointer
//   o_rd_ptr    current read pointer
//   o_free_ptr  first RAM address not yet released
// ----------------------------------------------------------------------------
module packet_rd_ptr
   import packet_reader_pkg::*;
#(
   parameter int pDEPTH_RAM  = PKT_DEPTH_RAM,
   parameter int pFIFO_WIDTH = $clog2(PKT_MAX_PACKET_LENGHT)
)(
   input  logic                          iclk,
   input  logic                          i_rst,
   input  logic                          i_inc,
   input  logic                          i_skip,
   input  logic [pFIFO_WIDTH-1:0]        i_skip_len,
   input  logic                          i_rel,
   output logic [$clog2(pDEPTH_RAM)-1:0] o_rd_ptr,
   output logic [$clog2(pDEPTH_RAM)-1:0] o_free_ptr
);

   localparam int AW = $clog2(pDEPTH_RAM);
   localparam logic [AW-1:0] LAST_ADDR = AW'(pDEPTH_RAM - 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(pDEPTH_RAM);

   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] rd_ptr_d;
   logic [AW-1:0] free_ptr_q;
   logic [AW-1:0] free_ptr_d;
   logic [AW:0]   skip_sum;

   // Next pointer values. The RAM depth is generally not a power of two, so
   // wrapping is done by comparing against the last address rather than by
   // letting the counter overflow. A length word is always shorter than the
   // RAM depth, so a single subtraction is enough to bring a skip back into
   // range.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      free_ptr_d = free_ptr_q;
      skip_sum   = {1'b0, rd_ptr_q} + (AW + 1)'(i_skip_len);

      if (i_skip) begin
         if (skip_sum > {1'b0, LAST_ADDR}) begin
            rd_ptr_d = AW'(skip_sum - DEPTH_EXT);
         end else begin
            rd_ptr_d = skip_sum[AW-1:0];
         end
      end else if (i_inc) begin
         if (rd_ptr_q == LAST_ADDR) begin
            rd_ptr_d = '0;
         end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end

      if (i_rel) begin
         free_ptr_d = rd_ptr_d;
      end
   end

   // Pointer registers
   always_ff @(posedge iclk) begin
      if (i_rst) begin
         rd_ptr_q   <= '0;
         free_ptr_q <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         free_ptr_q <= free_ptr_d;
      end
   end

   assign o_rd_ptr   = rd_ptr_q;
   assign o_free_ptr = free_ptr_q;

endmodule : packet_rd_ptr

// File: rtl/packet_reader.sv
// ----------------------------------------------------------------------------
// packet_reader
// Pulls frame lengths from a length FIFO, streams the matching bytes out of
// the packet RAM onto a transmit interface, releases the RAM afterwards and
// enforces an inter-packet gap. Illegal lengths are popped, flagged and their
// RAM skipped without transmitting anything.
//
// Ports
//   iclk          clock
//   i_rst         synchronous active-high reset
//   i_enable      permits starting a new packet
//   i_fifo_empty  length FIFO empty
//   i_fifo_len    head entry of the length FIFO
//   o_fifo_rd     one-cycle pop pulse to the length FIFO
//   o_rd_addr     packet RAM read address
//   i_rd_data     RAM read data, one cycle after the address
//   o_tx_d        transmit byte (0 when o_tx_en is low)
//   o_tx_en       transmit byte valid
//   o_free_ptr    first RAM address not yet released
//   o_len_err     one-cycle pulse when an illegal length is popped
//   o_busy        high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module packet_reader
   import packet_reader_pkg::*;
#(
   parameter int pDATA_WIDTH        = PKT_DATA_WIDTH,
   parameter int pMIN_PACKET_LENGHT = PKT_MIN_PACKET_LENGHT,
   parameter int pMAX_PACKET_LENGHT = PKT_MAX_PACKET_LENGHT,
   parameter int pFIFO_WIDTH        = $clog2(pMAX_PACKET_LENGHT),
   parameter int pDEPTH_RAM         = 2 * pMAX_PACKET_LENGHT,
   parameter int pIFG               = PKT_IFG
)(
   input  logic                          iclk,
   input  logic                          i_rst,
   input  logic                          i_enable,
   input  logic                          i_fifo_empty,
   input  logic [pFIFO_WIDTH-1:0]        i_fifo_len,
   output logic                          o_fifo_rd,
   output logic [$clog2(pDEPTH_RAM)-1:0] o_rd_addr,
   input  logic [pDATA_WIDTH-1:0]        i_rd_data,
   output logic [pDATA_WIDTH-1:0]        o_tx_d,
   output logic                          o_tx_en,
   output logic [$clog2(pDEPTH_RAM)-1:0] o_free_ptr,
   output logic                          o_len_err,
   output logic                          o_busy
);

   localparam int GW = $clog2(pIFG + 1);
   localparam logic [pFIFO_WIDTH-1:0] MAX_LEN = pFIFO_WIDTH'(pMAX_PACKET_LENGHT);

   // The GAP state itself is shorter than the full gap: the IDLE cycle that
   // samples the next start and the two-cycle RAM/output pipeline of the next
   // packet are also low cycles, so back-to-back packets see exactly pIFG.
   localparam logic [GW-1:0] GAP_LOAD = GW'(pIFG - 4);

   // Parameter sanity: the gap accounting above needs at least four cycles
   if (pIFG < 4 || pMIN_PACKET_LENGHT < 1 ||
       pMIN_PACKET_LENGHT > pMAX_PACKET_LENGHT) begin : g_bad_params
      $error("packet_reader: unsupported parameter combination");
   end

   pkt_rd_state_e state_q;
   pkt_rd_state_e state_d;

   logic [pFIFO_WIDTH-1:0] cnt_q;
   logic [pFIFO_WIDTH-1:0] cnt_d;
   logic [GW-1:0]          gap_q;
   logic [GW-1:0]          gap_d;
   logic                   fifo_rd_q;
   logic                   fifo_rd_d;
   logic                   len_err_q;
   logic                   len_err_d;
   logic                   rd_vld_q;
   logic                   rd_vld_d;
   logic                   tx_en_q;
   logic                   tx_en_d;
   logic [pDATA_WIDTH-1:0] tx_d_q;
   logic [pDATA_WIDTH-1:0] tx_d_d;

   logic start;
   logic len_zero;
   logic len_bad;
   logic ptr_inc;
   logic ptr_skip;
   logic ptr_rel;

   // Next-state and datapath control.
   // rd_vld marks the cycle in which i_rd_data carries a byte of the current
   // packet; the transmit register simply follows it one cycle later, which
   // gives the two-edge address-to-output latency with no bubbles.
   // A start is held off while the previous pop pulse is still out, so the
   // FIFO head that is about to be removed is never sampled a second time.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      fifo_rd_d = 1'b0;
      len_err_d = 1'b0;
      rd_vld_d  = 1'b0;
      ptr_inc   = 1'b0;
      ptr_skip  = 1'b0;
      ptr_rel   = 1'b0;
      tx_en_d   = rd_vld_q;
      tx_d_d    = rd_vld_q ? i_rd_data : '0;

      len_zero  = (i_fifo_len == '0);
      len_bad   = len_zero || (i_fifo_len > MAX_LEN);
      start     = (state_q == ST_IDLE) && i_enable && !i_fifo_empty && !fifo_rd_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               fifo_rd_d = 1'b1;
               cnt_d     = i_fifo_len;
               if (len_bad) begin
                  // Discard: skip the frame's RAM and release it at once
                  len_err_d = 1'b1;
                  ptr_skip  = !len_zero;
                  ptr_rel   = !len_zero;
               end else begin
                  state_d = ST_READ;
               end
            end
         end

         ST_READ: begin
            ptr_inc  = 1'b1;
            rd_vld_d = 1'b1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == pFIFO_WIDTH'(1)) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Last byte is on the output once nothing is left in the RAM stage
            if (tx_en_q && !rd_vld_q) begin
               ptr_rel = 1'b1;
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any packet in flight
   always_ff @(posedge iclk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         gap_q     <= '0;
         fifo_rd_q <= 1'b0;
         len_err_q <= 1'b0;
         rd_vld_q  <= 1'b0;
         tx_en_q   <= 1'b0;
         tx_d_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         fifo_rd_q <= fifo_rd_d;
         len_err_q <= len_err_d;
         rd_vld_q  <= rd_vld_d;
         tx_en_q   <= tx_en_d;
         tx_d_q    <= tx_d_d;
      end
   end

   packet_rd_ptr #(
      .pDEPTH_RAM  (pDEPTH_RAM),
      .pFIFO_WIDTH (pFIFO_WIDTH)
   ) u_rd_ptr (
      .iclk        (iclk),
      .i_rst       (i_rst),
      .i_inc       (ptr_inc),
      .i_skip      (ptr_skip),
      .i_skip_len  (i_fifo_len),
      .i_rel       (ptr_rel),
      .o_rd_ptr    (o_rd_addr),
      .o_free_ptr  (o_free_ptr)
   );

   assign o_fifo_rd = fifo_rd_q;
   assign o_len_err = len_err_q;
   assign o_tx_en   = tx_en_q;
   assign o_tx_d    = tx_d_q;
   assign o_busy    = (state_q != ST_IDLE);

endmodule : packet_reader

// File: tb/tb_packet_reader.sv
// ----------------------------------------------------------------------------
// tb_packet_reader
// Self-checking bench for packet_reader: behavioural RAM and length FIFO,
// a reference model that turns each queued length into the expected byte
// stream, and a monitor that compares every transmitted byte.
// ----------------------------------------------------------------------------
module tb_packet_reader;

   localparam int DEPTH   = 3072;
   localparam int MAX_LEN = 1536;
   localparam int IFG     = 12;

   logic        iclk = 1'b0;
   logic        i_rst;
   logic        i_enable;
   logic        i_fifo_empty;
   logic [10:0] i_fifo_len;
   logic        o_fifo_rd;
   logic [11:0] o_rd_addr;
   logic [7:0]  i_rd_data;
   logic [7:0]  o_tx_d;
   logic        o_tx_en;
   logic [11:0] o_free_ptr;
   logic        o_len_err;
   logic        o_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural RAM and length FIFO
   logic [7:0]  ram [0:DEPTH-1];
   logic [10:0] len_mem [0:255];
   int          push_cnt = 0;
   int          pop_cnt  = 0;
   int          bad_pops = 0;

   // Reference model state
   logic [7:0]  exp_q[$];
   int          gap_hist[$];
   int          model_ptr = 0;
   int          err_exp   = 0;
   bit          mon_en    = 1'b0;

   packet_reader dut (
      .iclk         (iclk),
      .i_rst        (i_rst),
      .i_enable     (i_enable),
      .i_fifo_empty (i_fifo_empty),
      .i_fifo_len   (i_fifo_len),
      .o_fifo_rd    (o_fifo_rd),
      .o_rd_addr    (o_rd_addr),
      .i_rd_data    (i_rd_data),
      .o_tx_d       (o_tx_d),
      .o_tx_en      (o_tx_en),
      .o_free_ptr   (o_free_ptr),
      .o_len_err    (o_len_err),
      .o_busy       (o_busy)
   );

   // Clock
   always #5 iclk = ~iclk;

   // RAM with one-cycle synchronous read
   always @(posedge iclk) begin
      i_rd_data <= ram[o_rd_addr];
   end

   // Length FIFO: head entry and empty flag, popped on o_fifo_rd
   assign i_fifo_empty = (pop_cnt == push_cnt);
   assign i_fifo_len   = len_mem[pop_cnt[7:0]];

   always @(posedge iclk) begin
      if (o_fifo_rd) begin
         if (pop_cnt == push_cnt) begin
            bad_pops <= bad_pops + 1;
         end else begin
            pop_cnt <= pop_cnt + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Queue one length into the FIFO and record what it should produce
   task automatic applyStimulus(input int len);
      len_mem[push_cnt % 256] = 11'(len);
      push_cnt++;
      if (len == 0 || len > MAX_LEN) begin
         err_exp++;
      end else begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_back(ram[(model_ptr + i) % DEPTH]);
         end
      end
      model_ptr = (model_ptr + len) % DEPTH;
   endtask

   task automatic waitDrained(input int budget, input bit rand_en);
      int n = 0;
      while (!((pop_cnt == push_cnt) && (exp_q.size() == 0) && (err_exp == 0) && !o_busy)
             && n < budget) begin
         @(negedge iclk);
         n++;
         if (rand_en) i_enable = ($urandom_range(0, 3) != 0);
      end
      if (rand_en) i_enable = 1'b1;
      checkOutput("drain_within_budget", (n < budget), 1);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge iclk);
   endtask

   // Monitor: compares transmitted bytes, error pulses and inter-packet gaps
   initial begin
      bit prev_tx  = 1'b0;
      bit seen_pkt = 1'b0;
      int low_run  = 0;
      forever begin
         @(negedge iclk);
         if (mon_en) begin
            if (o_tx_en) begin
               checkOutput("tx_expected", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0) checkOutput("tx_byte", o_tx_d, exp_q.pop_front());
               if (!prev_tx && seen_pkt) begin
                  gap_hist.push_back(low_run);
                  checkOutput("ifg_min", (low_run >= IFG), 1);
               end
               seen_pkt = 1'b1;
               low_run  = 0;
            end else begin
               low_run++;
               checkOutput("tx_d_zero_when_idle", o_tx_d, 0);
            end
            if (o_len_err) begin
               checkOutput("len_err_expected", (err_exp > 0), 1);
               if (err_exp > 0) err_exp--;
            end
            prev_tx = o_tx_en;
         end
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   // Stimulus
   initial begin
      int n;
      int seen;
      int pops0;
      int g;

      i_rst    = 1'b1;
      i_enable = 1'b0;
      for (int a = 0; a < DEPTH; a++) ram[a] = 8'($urandom);
      idleCycles(3);

      // Reset state
      checkOutput("rst_tx_en",    o_tx_en,    0);
      checkOutput("rst_tx_d",     o_tx_d,     0);
      checkOutput("rst_fifo_rd",  o_fifo_rd,  0);
      checkOutput("rst_len_err",  o_len_err,  0);
      checkOutput("rst_busy",     o_busy,     0);
      checkOutput("rst_free_ptr", o_free_ptr, 0);
      checkOutput("rst_rd_addr",  o_rd_addr,  0);
      i_rst  = 1'b0;
      mon_en = 1'b1;
      idleCycles(2);

      // Single packet of 64 with RAM[0..63] = 0..63
      for (int a = 0; a < 64; a++) ram[a] = 8'(a);
      pops0 = pop_cnt;
      applyStimulus(64);
      i_enable = 1'b1;
      @(negedge iclk);
      checkOutput("single_pop_pulse_e1", o_fifo_rd, 1);
      checkOutput("single_tx_low_e1",    o_tx_en,   0);
      checkOutput("single_busy",         o_busy,    1);
      @(negedge iclk);
      checkOutput("single_pop_once_e2",  o_fifo_rd, 0);
      checkOutput("single_tx_low_e2",    o_tx_en,   0);
      @(negedge iclk);
      checkOutput("single_tx_high_e3",   o_tx_en,   1);
      waitDrained(200, 1'b0);
      checkOutput("single_pops",     pop_cnt - pops0, 1);
      checkOutput("single_free_ptr", o_free_ptr, 64);

      // Back-to-back 64 and 100
      pops0 = pop_cnt;
      applyStimulus(64);
      applyStimulus(100);
      waitDrained(400, 1'b0);
      g = -1;
      if (gap_hist.size() > 0) g = gap_hist[gap_hist.size() - 1];
      checkOutput("b2b_gap",      g, IFG);
      checkOutput("b2b_pops",     pop_cnt - pops0, 2);
      checkOutput("b2b_free_ptr", o_free_ptr, 228);

      // Illegal lengths
      applyStimulus(0);
      waitDrained(50, 1'b0);
      checkOutput("len0_free_ptr", o_free_ptr, 228);
      applyStimulus(2000);
      waitDrained(50, 1'b0);
      checkOutput("len2000_free_ptr", o_free_ptr, (228 + 2000) % DEPTH);

      // Move the pointer to 3060, then a packet of 20 that wraps
      applyStimulus(832);
      waitDrained(1000, 1'b0);
      checkOutput("pre_wrap_free_ptr", o_free_ptr, 3060);
      for (int a = 3060; a < DEPTH; a++) ram[a] = 8'(8'hA0 + (a - 3060));
      for (int a = 0; a < 8; a++) ram[a] = 8'(8'hC0 + a);
      applyStimulus(20);
      waitDrained(100, 1'b0);
      checkOutput("wrap_free_ptr", o_free_ptr, 8);

      // Reset after byte 30 of 64
      applyStimulus(64);
      n    = 0;
      seen = 0;
      while (seen < 30 && n < 200) begin
         @(negedge iclk);
         n++;
         if (o_tx_en) seen++;
      end
      checkOutput("rst_mid_reached_byte30", seen, 30);
      i_enable = 1'b0;
      i_rst    = 1'b1;
      @(negedge iclk);
      checkOutput("rst_mid_tx_en",    o_tx_en,    0);
      checkOutput("rst_mid_free_ptr", o_free_ptr, 0);
      checkOutput("rst_mid_busy",     o_busy,     0);
      checkOutput("rst_mid_rd_addr",  o_rd_addr,  0);
      exp_q.delete();
      model_ptr = 0;
      i_rst     = 1'b0;
      pops0     = pop_cnt;
      applyStimulus(40);
      idleCycles(30);
      checkOutput("rst_mid_no_pop",  pop_cnt - pops0, 0);
      checkOutput("rst_mid_idle",    o_busy, 0);
      i_enable = 1'b1;
      waitDrained(200, 1'b0);
      checkOutput("restart_free_ptr", o_free_ptr, 40);

      // Enable dropped mid-packet
      pops0 = pop_cnt;
      applyStimulus(100);
      applyStimulus(50);
      n = 0;
      while (!o_tx_en && n < 50) begin
         @(negedge iclk);
         n++;
      end
      checkOutput("ctl_started", o_tx_en, 1);
      idleCycles(20);
      i_enable = 1'b0;
      n = 0;
      while (!(exp_q.size() == 50 && !o_busy) && n < 400) begin
         @(negedge iclk);
         n++;
      end
      idleCycles(40);
      checkOutput("ctl_first_complete", exp_q.size(), 50);
      checkOutput("ctl_one_pop",        pop_cnt - pops0, 1);
      checkOutput("ctl_held_idle",      o_busy, 0);
      i_enable = 1'b1;
      waitDrained(300, 1'b0);
      checkOutput("ctl_free_ptr", o_free_ptr, model_ptr);

      // Randomized traffic with random enable
      for (int k = 0; k < 25; k++) begin
         int burst;
         burst = $urandom_range(1, 3);
         for (int b = 0; b < burst; b++) begin
            if ($urandom_range(0, 9) == 0) begin
               applyStimulus(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 2047));
            end else begin
               applyStimulus($urandom_range(1, 160));
            end
         end
         waitDrained(3000, 1'b1);
         checkOutput("rand_free_ptr", o_free_ptr, model_ptr);
      end

      idleCycles(5);
      checkOutput("end_exp_empty",     exp_q.size(), 0);
      checkOutput("end_err_balance",   err_exp, 0);
      checkOutput("end_no_empty_pops", bad_pops, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_packet_reader

// File: doc/packet_reader.md
PACKET_READER -- requirements
Module: packet_reader

Interface
REQ-001 Parameters SHALL be: pDATA_WIDTH, default 8, byte width. pMIN_PACKET_LENGHT, default 64, minimum frame. pMAX_PACKET_LENGHT, default 1536, maximum frame. pFIFO_WIDTH, default $clog2(pMAX_PACKET_LENGHT), length word width. pDEPTH_RAM, default 2*pMAX_PACKET_LENGHT, packet RAM depth. pIFG, default 12, inter-packet gap in cycles.
REQ-002 Ports SHALL be, clock and reset first:
- iclk  in  1  single clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  permits starting a new packet.
- i_fifo_empty  in  1  length FIFO empty.
- i_fifo_len  in  pFIFO_WIDTH  head entry of the length FIFO, valid while i_fifo_empty=0.
- o_fifo_rd  out  1  pop pulse to the length FIFO.
- o_rd_addr  out  $clog2(pDEPTH_RAM)  packet RAM read address.
- i_rd_data  in  pDATA_WIDTH  RAM data, one-cycle synchronous read latency.
- o_tx_d  out  pDATA_WIDTH  transmit byte.
- o_tx_en  out  1  transmit byte valid.
- o_free_ptr  out  $clog2(pDEPTH_RAM)  first RAM address not yet released.
- o_len_err  out  1  one-cycle pulse on an illegal length.
- o_busy  out  1  high in every state except IDLE.
REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-high on i_rst.

Function
REQ-004 The FSM SHALL have the states IDLE, READ, DRAIN and GAP.
REQ-005 IDLE: on an edge E sampling i_enable=1 and i_fifo_empty=0:
- latch i_fifo_len into the byte counter;
- drive o_fifo_rd=1 for exactly the cycle after E;
- go to READ.
REQ-006 A length of 0 or greater than pMAX_PACKET_LENGHT SHALL still be popped, SHALL pulse o_len_err, and SHALL produce no o_tx_en. The FSM SHALL return to IDLE.
REQ-007 For an illegal length other than 0, the read pointer and o_free_ptr SHALL advance by the length, modulo pDEPTH_RAM. A length of 0 SHALL move no pointer.
REQ-008 READ: each cycle, o_rd_addr SHALL present the read pointer and the pointer SHALL then increment. The address after pDEPTH_RAM-1 SHALL be 0.
REQ-009 READ: the byte counter SHALL decrement once per address issued. READ SHALL go to DRAIN after the edge that issues the last address.
REQ-010 o_tx_d and o_tx_en SHALL be registered, with o_tx_d equal to the i_rd_data of the address issued two edges earlier.
REQ-011 o_tx_en SHALL first go high after edge E+2 and SHALL stay high for exactly len consecutive cycles, with no bubbles.
REQ-012 DRAIN SHALL wait until the last byte has been output. It SHALL then set o_free_ptr to the read pointer (the address after the last byte, wrapped) and go to GAP.
REQ-013 GAP SHALL hold o_tx_en low for exactly pIFG cycles after the last byte, then go to IDLE. A new start SHALL give at least pIFG low cycles between packets.
REQ-014 Deasserting i_enable mid-packet SHALL NOT truncate the packet; it only blocks the next start.
REQ-015 The length FIFO SHALL be popped only in IDLE, at most once per packet, and never while i_fifo_empty=1.
REQ-016 o_tx_d SHALL be 0 whenever o_tx_en=0.
REQ-017 The byte counter SHALL be pFIFO_WIDTH wide. The pointers SHALL be $clog2(pDEPTH_RAM) wide, and wrap SHALL be by explicit compare to pDEPTH_RAM-1, not natural overflow.

Reset
REQ-018 On i_rst=1 at any edge, including mid-packet, the block SHALL enter IDLE and clear the following:
- o_tx_en=0, o_tx_d=0, o_fifo_rd=0, o_len_err=0, o_busy=0;
- read pointer, o_rd_addr and o_free_ptr all set to 0;
- counters set to 0.
REQ-019 A packet interrupted by reset SHALL NOT release RAM and SHALL NOT be resumed.

Structure
REQ-020 The FSM state encodings and the shared defaults (pDATA_WIDTH, pMAX_PACKET_LENGHT, pDEPTH_RAM, pIFG) SHALL reside in a shared package that the packet writer also uses.
REQ-021 One sub-module, packet_rd_ptr, SHALL implement the wrapping read pointer and the o_free_ptr register. Everything else SHALL be flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single packet: FIFO holds 64, RAM[0..63]=0..63, i_enable=1 -> o_fifo_rd is one pulse; o_tx_en is high 64 cycles starting at E+2 with bytes 0x00..0x3F; o_free_ptr=64.
- Wrap: read pointer at 3060 (pDEPTH_RAM=3072), length 20 -> addresses 3060..3071 then 0..7; o_free_ptr=8.
- Back-to-back: lengths 64 and 100 queued -> exactly 12 low cycles between the packets; o_fifo_rd is pulsed twice in total.
- Illegal lengths: length 0 -> o_len_err pulse, no tx, pointer unchanged; length 2000 -> o_len_err pulse, pointer +2000 modulo 3072.
- Reset mid-packet after byte 30 of 64 -> o_tx_en is 0 on the next cycle; o_free_ptr=0; FSM is in IDLE; no further pop until restart.
- Control: i_enable dropped mid-packet -> the current packet completes; a queued packet does not start until i_enable=1.
